// File: rtl/multiplier_8x8b_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_8x8b_seq_if
// Description : Operand/product val-rdy bundle for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiplier_8x8b_seq_if;
    logic        in_val;
    logic        in_rdy;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] prod;
    logic        busy;

    modport master (
        output in_val, in0, in1, out_rdy,
        input  in_rdy, out_val, prod, busy
    );

    modport slave (
        input  in_val, in0, in1, out_rdy,
        output in_rdy, out_val, prod, busy
    );
endinterface
`default_nettype wire

// File: rtl/multiplier_8x8b_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_8x8b_seq
// Description : Iterative 8x8 unsigned shift-add multiplier, val/rdy in and out.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_8x8b_seq #(
    parameter bit FAST_TERM = 1'b0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    multiplier_8x8b_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_CNT = 3'd7;

    state_t      r_state;
    logic [15:0] r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;
    logic [15:0] r_prod;
    logic        r_in_rdy;
    logic        r_out_val;
    logic        r_busy;

    logic [15:0] w_pp;
    logic [15:0] w_acc_next;
    logic        w_last;

    // Single 1x8b AND stage; r_a's left shift supplies the bit weight.
    assign w_pp       = r_a & {16{r_b[0]}};
    assign w_acc_next = r_acc + w_pp;

    generate
        if (FAST_TERM) begin : g_fast_term
            assign w_last = ((r_b >> 1) == 8'h00) || (r_cnt == c_LAST_CNT);
        end else begin : g_full_term
            assign w_last = (r_cnt == c_LAST_CNT);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= 16'h0000;
            r_b       <= 8'h00;
            r_acc     <= 16'h0000;
            r_cnt     <= 3'd0;
            r_prod    <= 16'h0000;
            r_in_rdy  <= 1'b1;
            r_out_val <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_val) begin
                        r_a      <= {8'h00, bus.in0};
                        r_b      <= bus.in1;
                        r_acc    <= 16'h0000;
                        r_cnt    <= 3'd0;
                        r_state  <= S_CALC;
                        r_in_rdy <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_prod    <= w_acc_next;
                        r_out_val <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_rdy) begin
                        r_state   <= S_IDLE;
                        r_out_val <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_out_val <= 1'b0;
                    r_in_rdy  <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_rdy  = r_in_rdy;
    assign bus.out_val = r_out_val;
    assign bus.prod    = r_prod;
    assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_8x8b_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_8x8b_seq
// Description : Self-checking bench for both FAST_TERM builds of the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_8x8b_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiplier_8x8b_seq_if if0 ();
    multiplier_8x8b_seq_if if1 ();

    multiplier_8x8b_seq #(.FAST_TERM(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    multiplier_8x8b_seq #(.FAST_TERM(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    logic        in_val  [2];
    logic [7:0]  in0     [2];
    logic [7:0]  in1     [2];
    logic        out_rdy [2];
    logic        in_rdy_w  [2];
    logic        out_val_w [2];
    logic        busy_w    [2];
    logic [15:0] prod_w    [2];

    assign if0.in_val  = in_val[0];
    assign if0.in0     = in0[0];
    assign if0.in1     = in1[0];
    assign if0.out_rdy = out_rdy[0];
    assign if1.in_val  = in_val[1];
    assign if1.in0     = in0[1];
    assign if1.in1     = in1[1];
    assign if1.out_rdy = out_rdy[1];
    assign in_rdy_w[0]  = if0.in_rdy;
    assign in_rdy_w[1]  = if1.in_rdy;
    assign out_val_w[0] = if0.out_val;
    assign out_val_w[1] = if1.out_val;
    assign busy_w[0]    = if0.busy;
    assign busy_w[1]    = if1.busy;
    assign prod_w[0]    = if0.prod;
    assign prod_w[1]    = if1.prod;

    int checks = 0;
    int errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat0;
        int          lat1;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [15:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic pop(input int d, output logic [15:0] v, output bit ok);
        ok = 1'b1;
        v  = 16'h0;
        if (d == 0) begin
            if (q0.size() == 0) ok = 1'b0; else v = q0.pop_front();
        end else begin
            if (q1.size() == 0) ok = 1'b0; else v = q1.pop_front();
        end
    endtask

    task automatic start_op(input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp);
        int n = 0;
        while (!in_rdy_w[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_rdy_wait", {31'd0, in_rdy_w[d]}, 32'd1);
        in0[d] = a;
        in1[d] = b;
        in_val[d] = 1'b1;
        @(posedge clk); #1;
        in_val[d] = 1'b0;
        push(d, exp);
        chk("accept_in_rdy", {31'd0, in_rdy_w[d]}, 32'd0);
        chk("accept_busy", {31'd0, busy_w[d]}, 32'd1);
    endtask

    task automatic wait_out(input int d, input int exp_lat);
        int k = 0;
        while (!out_val_w[d] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("latency_dut%0d", d), k, exp_lat);
    endtask

    task automatic finish_op(input int d);
        logic [15:0] exp;
        bit ok;
        pop(d, exp, ok);
        chk("scoreboard_nonempty", {31'd0, ok}, 32'd1);
        chk($sformatf("prod_dut%0d", d), {16'd0, prod_w[d]}, {16'd0, exp});
        @(posedge clk); #1;
        chk("out_val_drop", {31'd0, out_val_w[d]}, 32'd0);
        chk("back_idle", {31'd0, in_rdy_w[d]}, 32'd1);
        chk("prod_hold", {16'd0, prod_w[d]}, {16'd0, exp});
    endtask

    initial begin
        vecs[0] = '{8'd3,   8'd5,   16'h000F, 8, 3};
        vecs[1] = '{8'hFF,  8'hFF,  16'hFE01, 8, 8};
        vecs[2] = '{8'h80,  8'h02,  16'h0100, 8, 2};
        vecs[3] = '{8'h00,  8'hA5,  16'h0000, 8, 8};
        vecs[4] = '{8'h5A,  8'h00,  16'h0000, 8, 1};
        vecs[5] = '{8'hC8,  8'h01,  16'h00C8, 8, 1};
        vecs[6] = '{8'h03,  8'h80,  16'h0180, 8, 8};
        vecs[7] = '{8'd7,   8'd9,   16'h003F, 8, 4};
        vecs[8] = '{8'd12,  8'd10,  16'h0078, 8, 4};

        for (int d = 0; d < 2; d++) begin
            in_val[d]  = 1'b0;
            in0[d]     = 8'h00;
            in1[d]     = 8'h00;
            out_rdy[d] = 1'b1;
        end

        // Reset state, then idle cycles with no in_val must not start anything.
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_rdy", {31'd0, in_rdy_w[d]}, 32'd1);
            chk("rst_out_val", {31'd0, out_val_w[d]}, 32'd0);
            chk("rst_busy", {31'd0, busy_w[d]}, 32'd0);
            chk("rst_prod", {16'd0, prod_w[d]}, 32'd0);
        end
        #5 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_accept", {31'd0, busy_w[0]}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            for (int d = 0; d < 2; d++) begin
                start_op(d, vecs[i].a, vecs[i].b, vecs[i].p);
                wait_out(d, (d == 0) ? vecs[i].lat0 : vecs[i].lat1);
                finish_op(d);
            end
        end

        // Backpressure on the full-latency build with input noise during DONE.
        start_op(0, 8'd12, 8'd10, 16'h0078);
        out_rdy[0] = 1'b0;
        wait_out(0, 8);
        for (int c = 0; c < 5; c++) begin
            in0[0] = 8'($urandom);
            in1[0] = 8'($urandom);
            in_val[0] = ~in_val[0];
            @(posedge clk); #1;
            chk("bp_out_val", {31'd0, out_val_w[0]}, 32'd1);
            chk("bp_prod", {16'd0, prod_w[0]}, 32'h0078);
            chk("bp_in_rdy", {31'd0, in_rdy_w[0]}, 32'd0);
        end
        in_val[0] = 1'b0;
        out_rdy[0] = 1'b1;
        finish_op(0);

        // Asynchronous reset between E4 and E5 must act without a clock edge.
        start_op(0, 8'd200, 8'd100, 16'h4E20);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_in_rdy", {31'd0, in_rdy_w[0]}, 32'd1);
        chk("arst_out_val", {31'd0, out_val_w[0]}, 32'd0);
        chk("arst_prod", {16'd0, prod_w[0]}, 32'd0);
        chk("arst_busy", {31'd0, busy_w[0]}, 32'd0);
        q0.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        start_op(0, 8'd7, 8'd9, 16'h003F);
        wait_out(0, 8);
        finish_op(0);

        // Back-to-back FAST_TERM ops with B=1: one op every 3 cycles.
        begin
            logic [7:0]  as[4];
            logic [15:0] exp;
            logic [15:0] prod_pre;
            bit          ok;
            bit          acc_now;
            bit          hs;
            int          idx   = 0;
            int          pops  = 0;
            int          edges = 0;
            as[0] = 8'hC8; as[1] = 8'h11; as[2] = 8'hFF; as[3] = 8'h02;
            out_rdy[1] = 1'b1;
            in0[1] = as[0];
            in1[1] = 8'h01;
            in_val[1] = 1'b1;
            while ((idx < 4 || pops < 4) && edges < 40) begin
                acc_now  = in_val[1] && in_rdy_w[1];
                hs       = out_val_w[1] && out_rdy[1];
                prod_pre = prod_w[1];
                @(posedge clk); #1;
                edges++;
                if (hs) begin
                    pop(1, exp, ok);
                    chk("b2b_nonempty", {31'd0, ok}, 32'd1);
                    chk("b2b_prod", {16'd0, prod_pre}, {16'd0, exp});
                    pops++;
                end
                if (acc_now) begin
                    push(1, {8'h00, in0[1]});
                    idx++;
                    if (idx < 4) in0[1] = as[idx];
                    else         in_val[1] = 1'b0;
                end
            end
            chk("b2b_edges", edges, 12);
            chk("b2b_pops", pops, 4);
        end

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
